// File: rtl/clint_core.sv
// clint_core: core-local interruptor (RISC-V CLINT) for a single hart.
// Holds msip, the 64-bit mtimecmp compare register and the free-running
// 64-bit mtime counter, and answers single-cycle bus requests.
// Optional feature: define CLINT_MTIME_WR_EN to make mtime writable over the
// bus at offsets 0xBFF8/0xBFFC. Without it mtime is read-only.
module clint_core #(
  parameter int unsigned TIME_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clint_valid,
  input  logic        clint_instr,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);

  // Prescaler width; a 1-bit counter is kept even when TIME_DIV is 1.
  localparam int unsigned PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIME_DIV - 1);

  // Word offsets of the register map (byte offsets, low two bits zero).
  localparam logic [31:0] OFS_MSIP     = 32'h0000_0000;
  localparam logic [31:0] OFS_CMP_LO   = 32'h0000_4000;
  localparam logic [31:0] OFS_CMP_HI   = 32'h0000_4004;
  localparam logic [31:0] OFS_MTIME_LO = 32'h0000_BFF8;
  localparam logic [31:0] OFS_MTIME_HI = 32'h0000_BFFC;

  // Byte-granular merge of write data into an existing word.
  function automatic logic [31:0] f_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  // State registers
  logic [PW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_msip;
  logic          r_mtip;
  logic          r_ready;
  logic [31:0]   r_rdata;

  // Decode and next-state wires
  logic [31:0] w_waddr;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic [31:0] w_rd_data;
  logic [63:0] w_mtime_nxt;
  logic [63:0] w_mtimecmp_nxt;
  logic        w_msip_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic        w_unused;

  // Fetch qualifier and byte-lane address bits carry no meaning here.
  assign w_unused = &{1'b0, clint_instr, clint_addr[1:0]};

  assign w_waddr = {clint_addr[31:2], 2'b00};
  assign w_wr    = clint_valid & (|clint_wstrb);
  assign w_rd    = clint_valid & ~(|clint_wstrb);
  assign w_tick  = (r_presc == PRESC_MAX);

  // Prescaler next value: wraps to zero on the mtime increment edge.
  always_comb begin
    w_presc_nxt = r_presc;
    if (w_tick) begin
      w_presc_nxt = {PW{1'b0}};
    end else begin
      w_presc_nxt = r_presc + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Read mux over pre-edge register values; unmapped offsets read zero.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    case (w_waddr)
      OFS_MSIP:     w_rd_data = {31'h0000_0000, r_msip};
      OFS_CMP_LO:   w_rd_data = r_mtimecmp[31:0];
      OFS_CMP_HI:   w_rd_data = r_mtimecmp[63:32];
      OFS_MTIME_LO: w_rd_data = r_mtime[31:0];
      OFS_MTIME_HI: w_rd_data = r_mtime[63:32];
      default:      w_rd_data = 32'h0000_0000;
    endcase
  end

  // mtimecmp next value: byte-merged bus writes to either half.
  always_comb begin
    w_mtimecmp_nxt = r_mtimecmp;
    if (w_wr && (w_waddr == OFS_CMP_LO)) begin
      w_mtimecmp_nxt[31:0] = f_merge(r_mtimecmp[31:0], clint_wdata, clint_wstrb);
    end else if (w_wr && (w_waddr == OFS_CMP_HI)) begin
      w_mtimecmp_nxt[63:32] = f_merge(r_mtimecmp[63:32], clint_wdata, clint_wstrb);
    end else begin
      w_mtimecmp_nxt = r_mtimecmp;
    end
  end

  // msip next value: only bit0, only when its byte lane is strobed.
  always_comb begin
    w_msip_nxt = r_msip;
    if (w_wr && (w_waddr == OFS_MSIP) && clint_wstrb[0]) begin
      w_msip_nxt = clint_wdata[0];
    end else begin
      w_msip_nxt = r_msip;
    end
  end

`ifdef CLINT_MTIME_WR_EN
  // mtime next value: a bus write wins over a same-edge increment, and the
  // full 64-bit add keeps the low-to-high carry atomic.
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_wr && (w_waddr == OFS_MTIME_LO)) begin
      w_mtime_nxt[31:0] = f_merge(r_mtime[31:0], clint_wdata, clint_wstrb);
    end else if (w_wr && (w_waddr == OFS_MTIME_HI)) begin
      w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], clint_wdata, clint_wstrb);
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end else begin
      w_mtime_nxt = r_mtime;
    end
  end
`else
  // mtime next value: read-only counter, increments on every prescaler wrap.
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end else begin
      w_mtime_nxt = r_mtime;
    end
  end
`endif

  // Timer state: prescaler and mtime counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= {PW{1'b0}};
      r_mtime <= 64'h0000_0000_0000_0000;
    end else begin
      r_presc <= w_presc_nxt;
      r_mtime <= w_mtime_nxt;
    end
  end

  // Software-visible control registers: mtimecmp and msip.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip     <= 1'b0;
    end else begin
      r_mtimecmp <= w_mtimecmp_nxt;
      r_msip     <= w_msip_nxt;
    end
  end

  // Timer interrupt: level compare on pre-edge values, one cycle behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  // Bus response: one ready pulse per sampled request; data only on reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0000_0000;
    end else begin
      r_ready <= clint_valid;
      if (w_rd) begin
        r_rdata <= w_rd_data;
      end else begin
        r_rdata <= 32'h0000_0000;
      end
    end
  end

  assign clint_rdata = r_rdata;
  assign clint_ready = r_ready;
  assign clint_msip  = r_msip;
  assign clint_mtip  = r_mtip;
  assign clint_mtime = r_mtime;

endmodule

// File: tb/tb_clint_core.sv
// tb_clint_core: randomized and directed checks of clint_core against a
// behavioural model. Two instances (TIME_DIV=1 and TIME_DIV=3) share inputs.
module tb_clint_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b;
  logic        msip_a, msip_b;
  logic        mtip_a, mtip_b;
  logic [63:0] mtime_a, mtime_b;

  // 10 time-unit clock
  always #5 clock = ~clock;

  clint_core #(.TIME_DIV(1)) u_dut_a (
    .clock(clock), .reset(reset), .clint_valid(valid), .clint_instr(instr),
    .clint_addr(addr), .clint_wdata(wdata), .clint_wstrb(wstrb),
    .clint_rdata(rdata_a), .clint_ready(ready_a), .clint_msip(msip_a),
    .clint_mtip(mtip_a), .clint_mtime(mtime_a)
  );

  clint_core #(.TIME_DIV(3)) u_dut_b (
    .clock(clock), .reset(reset), .clint_valid(valid), .clint_instr(instr),
    .clint_addr(addr), .clint_wdata(wdata), .clint_wstrb(wstrb),
    .clint_rdata(rdata_b), .clint_ready(ready_b), .clint_msip(msip_b),
    .clint_mtip(mtip_b), .clint_mtime(mtime_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = TIME_DIV 1, index 1 = TIME_DIV 3
  int          m_div   [2] = '{1, 3};
  int          m_presc [2];
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2];
  logic        m_msip  [2];
  logic        m_mtip  [2];
  logic        m_ready [2];
  logic [31:0] m_rdata [2];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0000) return {31'd0, m_msip[k]};
    if (w == 32'h0000_4000) return m_cmp[k][31:0];
    if (w == 32'h0000_4004) return m_cmp[k][63:32];
    if (w == 32'h0000_BFF8) return m_mtime[k][31:0];
    if (w == 32'h0000_BFFC) return m_mtime[k][63:32];
    return 32'h0;
  endfunction

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] w;
    logic        wr, tick, mt_wr;
    w = {addr[31:2], 2'b00};
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_mtime[k] = 64'd0; m_presc[k] = 0; m_cmp[k] = '1; m_msip[k] = 1'b0;
        m_ready[k] = 1'b0; m_rdata[k] = 32'd0; m_mtip[k] = 1'b0;
      end else begin
        wr = valid && (wstrb != 4'd0);
        m_ready[k] = valid;
        m_rdata[k] = (valid && !wr) ? model_read(k, addr) : 32'd0;
        m_mtip[k]  = (m_mtime[k] >= m_cmp[k]);
        tick = (m_presc[k] == m_div[k] - 1);
        m_presc[k] = tick ? 0 : m_presc[k] + 1;
        mt_wr = 1'b0;
        if (wr) begin
          if (w == 32'h0000_0000 && wstrb[0]) m_msip[k] = wdata[0];
          if (w == 32'h0000_4000) m_cmp[k][31:0]  = merge(m_cmp[k][31:0], wdata, wstrb);
          if (w == 32'h0000_4004) m_cmp[k][63:32] = merge(m_cmp[k][63:32], wdata, wstrb);
`ifdef CLINT_MTIME_WR_EN
          if (w == 32'h0000_BFF8) begin
            m_mtime[k][31:0] = merge(m_mtime[k][31:0], wdata, wstrb); mt_wr = 1'b1;
          end
          if (w == 32'h0000_BFFC) begin
            m_mtime[k][63:32] = merge(m_mtime[k][63:32], wdata, wstrb); mt_wr = 1'b1;
          end
`endif
        end
        if (!mt_wr && tick) m_mtime[k] = m_mtime[k] + 64'd1;
      end
    end
  endtask

  // One clock: update model at the edge, then compare all outputs 1 unit later.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_val("ready_a", {63'd0, ready_a}, {63'd0, m_ready[0]});
    check_val("rdata_a", {32'd0, rdata_a}, {32'd0, m_rdata[0]});
    check_val("msip_a",  {63'd0, msip_a},  {63'd0, m_msip[0]});
    check_val("mtip_a",  {63'd0, mtip_a},  {63'd0, m_mtip[0]});
    check_val("mtime_a", mtime_a, m_mtime[0]);
    check_val("ready_b", {63'd0, ready_b}, {63'd0, m_ready[1]});
    check_val("rdata_b", {32'd0, rdata_b}, {32'd0, m_rdata[1]});
    check_val("msip_b",  {63'd0, msip_b},  {63'd0, m_msip[1]});
    check_val("mtip_b",  {63'd0, mtip_b},  {63'd0, m_mtip[1]});
    check_val("mtime_b", mtime_b, m_mtime[1]);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    step();
    valid = 1'b0; wstrb = 4'd0;
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic [31:0] offs [6] = '{32'h0000_0000, 32'h0000_4000, 32'h0000_4004,
                            32'h0000_BFF8, 32'h0000_BFFC, 32'h0000_1234};

  initial begin
    reset = 1'b1; valid = 1'b0; instr = 1'b0;
    addr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
    step();
    do_reset();

    // Idle after reset: mtime counts every cycle at TIME_DIV 1
    do_idle(10);
    check_val("idle_mtime", mtime_a, 64'd10);
    check_val("idle_mtip",  {63'd0, mtip_a},  64'd0);
    check_val("idle_msip",  {63'd0, msip_a},  64'd0);
    check_val("idle_ready", {63'd0, ready_a}, 64'd0);

    // msip set, read back, masked write, clear
    do_req(32'h0000_0000, 32'h0000_0001, 4'b0001);
    check_val("msip_wr_ready", {63'd0, ready_a}, 64'd1);
    check_val("msip_wr_rdata", {32'd0, rdata_a}, 64'd0);
    check_val("msip_set",      {63'd0, msip_a},  64'd1);
    do_req(32'h0000_0000, 32'h0000_0000, 4'b0000);
    check_val("msip_rd", {32'd0, rdata_a}, 64'd1);
    do_req(32'h0000_0000, 32'hFFFF_FFFF, 4'b1110);
    check_val("msip_keep", {63'd0, msip_a}, 64'd1);
    do_req(32'h0000_0000, 32'h0000_0000, 4'b0001);
    check_val("msip_clr", {63'd0, msip_a}, 64'd0);

    // mtimecmp = 0x20: mtip rises one cycle after mtime reaches it
    do_req(32'h0000_4004, 32'h0000_0000, 4'b1111);
    do_req(32'h0000_4000, 32'h0000_0020, 4'b1111);
    for (int i = 0; i < 200 && mtime_a < 64'h20; i++) step();
    check_val("mtime_reach", mtime_a, 64'h20);
    step();
    check_val("mtip_rise", {63'd0, mtip_a}, 64'd1);
    do_req(32'h0000_4004, 32'hFFFF_FFFF, 4'b1111);
    check_val("mtip_hold", {63'd0, mtip_a}, 64'd1);
    step();
    check_val("mtip_fall", {63'd0, mtip_a}, 64'd0);

    // Low-word write to mtime and the carry into the high word
    do_req(32'h0000_BFF8, 32'hFFFF_FFFF, 4'b1111);
    check_val("mt_wr_ready", {63'd0, ready_a}, 64'd1);
`ifdef CLINT_MTIME_WR_EN
    check_val("mt_wr_val", mtime_a, 64'h0000_0000_FFFF_FFFF);
    step();
    check_val("mt_carry", mtime_a, 64'h0000_0001_0000_0000);
`else
    check_val("mt_wr_drop", {32'd0, mtime_a[63:32]}, 64'd0);
    step();
`endif

    // Back-to-back reads after reset
    do_reset();
    do_req(32'h0000_4000, 32'd0, 4'd0);
    check_val("b2b_rd0", {32'd0, rdata_a}, 64'hFFFF_FFFF);
    check_val("b2b_rdy0", {63'd0, ready_a}, 64'd1);
    do_req(32'h0000_1234, 32'd0, 4'd0);
    check_val("b2b_rd1", {32'd0, rdata_a}, 64'd0);
    check_val("b2b_rdy1", {63'd0, ready_a}, 64'd1);
    do_req(32'h0000_BFFC, 32'd0, 4'd0);
    check_val("b2b_rd2", {32'd0, rdata_a}, 64'd0);
    check_val("b2b_rdy2", {63'd0, ready_a}, 64'd1);

    // Reset during the second of two requests drops it
    do_req(32'h0000_4000, 32'd0, 4'd0);
    reset = 1'b1; valid = 1'b1; addr = 32'h0000_1234; wstrb = 4'd0;
    step();
    reset = 1'b0; valid = 1'b0;
    step();
    check_val("rst_drop_a", {63'd0, ready_a}, 64'd0);
    check_val("rst_drop_b", {63'd0, ready_b}, 64'd0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      valid = $urandom_range(0, 1);
      instr = $urandom_range(0, 1);
      addr  = offs[$urandom_range(0, 5)] | {30'd0, 2'($urandom_range(0, 3))};
      wstrb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       wdata = m_mtime[0][31:0] + 32'($urandom_range(0, 24));
        1:       wdata = 32'd0;
        default: wdata = $urandom;
      endcase
      step();
    end
    reset = 1'b0; valid = 1'b0; wstrb = 4'd0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
